// File: rtl/carregador_de_programa_if.sv
`default_nettype none
// ============================================================================
// Module   : carregador_de_programa_if
// Brief    : Byte-stream, instruction-memory write and status bundle of the
//            program loader. master = the loader, slave = its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface carregador_de_programa_if #(
  parameter int ADDR_WIDTH = 26
);
  logic                  start;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_data;
  logic                  busy;
  logic                  cpu_reset;
  logic                  done;
  logic                  erro;

  modport master (
    input  start, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_data, busy, cpu_reset, done, erro
  );

  modport slave (
    output start, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_data, busy, cpu_reset, done, erro
  );
endinterface
`default_nettype wire

// File: rtl/carregador_de_programa.sv
`default_nettype none
// ============================================================================
// Module   : carregador_de_programa
// Brief    : Loads a big-endian program image (16-bit word count followed by
//            4 bytes per word) from a byte stream into instruction memory,
//            starting at BASE_ADDR, holding the CPU in reset meanwhile.
//            Optional macro CARREGADOR_CHECKSUM_EN adds a trailing XOR
//            checksum byte over all data bytes.
// Revision : 1.0 - initial release
// ============================================================================
module carregador_de_programa #(
  parameter int ADDR_WIDTH = 26,
  parameter int MEM_SIZE   = 150,
  parameter int BASE_ADDR  = 0
) (
  input  wire clock,
  input  wire reset,
  carregador_de_programa_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6,
    S_ERRO   = 3'd7
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] C_BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [15:0]           C_MEM_SIZE = 16'(MEM_SIZE);

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_len_hi;
  logic [15:0]           r_count;
  logic [1:0]            r_byte_cnt;
  logic [31:0]           r_shift;
  logic [ADDR_WIDTH-1:0] r_addr;
`ifdef CARREGADOR_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic        w_byte_ready;
  logic        w_mem_we;
  logic        w_busy;
  logic        w_accept;
  logic [15:0] w_len;

  assign w_accept = bus.byte_valid & w_byte_ready;
  assign w_len    = {r_len_hi, bus.byte_in};

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and per-state output decode
  always_comb begin
    w_next       = r_state;
    w_byte_ready = 1'b0;
    w_mem_we     = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERRO: begin
        if (bus.start) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        w_byte_ready = 1'b1;
        w_busy       = 1'b1;
        if (bus.byte_valid) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        w_byte_ready = 1'b1;
        w_busy       = 1'b1;
        if (bus.byte_valid) begin
          if (w_len == 16'd0) begin
`ifdef CARREGADOR_CHECKSUM_EN
            w_next = S_CHECK;   // empty image still carries a 00 checksum
`else
            w_next = S_DONE;
`endif
          end else if (w_len > C_MEM_SIZE) begin
            w_next = S_ERRO;
          end else begin
            w_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        w_byte_ready = 1'b1;
        w_busy       = 1'b1;
        if (bus.byte_valid && r_byte_cnt == 2'd3) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_mem_we = 1'b1;
        w_busy   = 1'b1;
        if (r_count == 16'd1) begin
`ifdef CARREGADOR_CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = S_DONE;
`endif
        end else begin
          w_next = S_DATA;
        end
      end
`ifdef CARREGADOR_CHECKSUM_EN
      S_CHECK: begin
        w_byte_ready = 1'b1;
        w_busy       = 1'b1;
        if (bus.byte_valid) w_next = (bus.byte_in == r_csum) ? S_DONE : S_ERRO;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: length capture, byte assembly, address and word counting
  always_ff @(posedge clock) begin
    if (reset) begin
      r_len_hi   <= 8'd0;
      r_count    <= 16'd0;
      r_byte_cnt <= 2'd0;
      r_shift    <= 32'd0;
      r_addr     <= C_BASE;
`ifdef CARREGADOR_CHECKSUM_EN
      r_csum     <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERRO: begin
          if (bus.start) begin
            r_addr     <= C_BASE;
            r_byte_cnt <= 2'd0;
`ifdef CARREGADOR_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
          end
        end
        S_LEN_HI: if (w_accept) r_len_hi <= bus.byte_in;
        S_LEN_LO: if (w_accept) r_count <= w_len;
        S_DATA: begin
          if (w_accept) begin
            r_shift    <= {r_shift[23:0], bus.byte_in};
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef CARREGADOR_CHECKSUM_EN
            r_csum     <= r_csum ^ bus.byte_in;
`endif
          end
        end
        S_WRITE: begin
          r_addr  <= r_addr + C_ADDR_ONE;
          r_count <= r_count - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.byte_ready = w_byte_ready;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_data   = r_shift;
  assign bus.busy       = w_busy;
  assign bus.cpu_reset  = w_busy;
  assign bus.done       = (r_state == S_DONE);
  assign bus.erro       = (r_state == S_ERRO);

endmodule
`default_nettype wire

// File: tb/tb_carregador_de_programa.sv
`default_nettype none
// ============================================================================
// Module   : tb_carregador_de_programa
// Brief    : Randomized scoreboard bench for carregador_de_programa.
// Revision : 1.0 - initial release
// ============================================================================
module tb_carregador_de_programa;

  localparam int AW       = 26;
  localparam int MEM_SIZE = 150;
  localparam int BASE     = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;

  carregador_de_programa_if #(.ADDR_WIDTH(AW)) bus ();

  carregador_de_programa #(
    .ADDR_WIDTH(AW), .MEM_SIZE(MEM_SIZE), .BASE_ADDR(BASE)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  logic [31:0]   words[$];

  int cyc            = 0;
  int last_we_cyc    = -1;
  int first_done_cyc = -1;
  logic done_d       = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the scoreboard queue
  always @(negedge clock) begin
    cyc++;
    check("cpu_reset_eq_busy", 64'(bus.cpu_reset), 64'(bus.busy));
    if (bus.mem_we) begin
      last_we_cyc = cyc;
      check("ready_low_in_write", 64'(bus.byte_ready), 64'd0);
      if (exp_addr_q.size() == 0) begin
        check("unexpected_write_addr", 64'(bus.mem_addr), 64'hFFFF_FFFF);
      end else begin
        check("write_addr", 64'(bus.mem_addr), 64'(exp_addr_q.pop_front()));
        check("write_data", 64'(bus.mem_data), 64'(exp_data_q.pop_front()));
      end
    end
    if (bus.done && !done_d) first_done_cyc = cyc;
    done_d = bus.done;
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int count, input int gap_max);
    for (int i = 0; i < count; i++) begin
      int  tries;
      bit  acc;
      tries = 0;
      bus.byte_valid = 1'b1;
      bus.byte_in    = s[i];
      do begin
        @(negedge clock);
        acc = bus.byte_ready;
        @(posedge clock); #1;
        tries++;
      end while (!acc && tries < 200);
      if (!acc) begin
        check("byte_accept_timeout", 64'd0, 64'd1);
        bus.byte_valid = 1'b0;
        return;
      end
      bus.byte_valid = 1'b0;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clock); #1; end
    end
  endtask

  task automatic check_reset_values(input string name);
    check(name, {bus.byte_ready, bus.mem_we, bus.busy, bus.cpu_reset, bus.done, bus.erro},
          6'b000000);
    check({name, "_addr"}, 64'(bus.mem_addr), 64'(BASE));
    check({name, "_data"}, 64'(bus.mem_data), 64'd0);
  endtask

  // Reference model: build the stream and expected writes from the word list
  task automatic do_load(input int n, input bit corrupt, input int gap_max);
    logic [7:0] s[$];
    logic [7:0] x;
    logic [15:0] n16;
    logic [31:0] w;
    bit exp_err;
    int t;
    x   = 8'h00;
    n16 = 16'(n);
    s.push_back(n16[15:8]);
    s.push_back(n16[7:0]);
    exp_err = (n > MEM_SIZE);
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        w = words[i];
        for (int b = 3; b >= 0; b--) begin
          s.push_back(w[b*8 +: 8]);
          x = x ^ w[b*8 +: 8];
        end
        exp_addr_q.push_back(AW'(BASE + i));
        exp_data_q.push_back(w);
      end
    end
`ifdef CARREGADOR_CHECKSUM_EN
    if (!exp_err) begin
      s.push_back(corrupt ? (x ^ 8'h03) : x);
      if (corrupt) exp_err = 1'b1;
    end
`endif
    pulse_start();
    check("busy_after_start", 64'(bus.busy), 64'd1);
    send_stream(s, s.size(), gap_max);
    t = 0;
    do begin
      @(negedge clock); #1;
      t++;
    end while (!(bus.done || bus.erro) && t < 2000);
    check("load_finished", 64'(bus.done | bus.erro), 64'd1);
    check("done", 64'(bus.done), 64'(!exp_err));
    check("erro", 64'(bus.erro), 64'(exp_err));
    check("busy_end", 64'(bus.busy), 64'd0);
    check("cpu_reset_end", 64'(bus.cpu_reset), 64'd0);
    check("addr_end", 64'(bus.mem_addr), 64'((n > MEM_SIZE) ? BASE : BASE + n));
    check("all_writes_seen", 64'(exp_addr_q.size()), 64'd0);
`ifndef CARREGADOR_CHECKSUM_EN
    if (n > 0 && !exp_err)
      check("done_right_after_last_write", 64'(first_done_cyc - last_we_cyc), 64'd1);
`endif
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clock); #1;
  endtask

  task automatic random_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    logic [7:0] s5[$];
    bus.start      = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("reset_state");
    reset = 1'b0;
    @(posedge clock); #1;

    // Single word image
    words = '{32'h5800_0001};
    do_load(1, 1'b0, 0);

    // Three words, back-to-back then with random valid gaps
    words = '{32'h0400_0001, 32'h4C14_0000, 32'h6000_0000};
    do_load(3, 1'b0, 0);
    do_load(3, 1'b0, 3);

    // Length boundaries
    do_load(151, 1'b0, 0);
    do_load(0, 1'b0, 0);
    random_words(150);
    do_load(150, 1'b0, 0);

`ifdef CARREGADOR_CHECKSUM_EN
    words = '{32'h5800_0001};
    do_load(1, 1'b1, 0);
`endif

    // Randomized loads
    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(0, 7);
      random_words(n);
      do_load(n, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // Reset in the middle of a three-word load after six data bytes
    words = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
    s5 = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_addr_q.push_back(AW'(BASE));
    exp_data_q.push_back(32'h1122_3344);
    pulse_start();
    send_stream(s5, 8, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    check_reset_values("mid_load_reset");
    reset = 1'b0;
    check("one_write_before_reset", 64'(exp_addr_q.size()), 64'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clock); #1;
    do_load(3, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
